fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin arbiter for two framebuffer write requesters,
// with an optional clear sequencer. The sequencer fills the whole framebuffer
// with CLEAR_COLOR.
// Optional feature macro: FB_ARB_CLEAR_EN (defined -> clear sequencer present).
module fb_write_arbiter #(
  parameter int          PIXEL_COUNT = 307200,
  parameter logic [7:0]  CLEAR_COLOR = 8'h00
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        addr_err,
  output logic        cpu_wr,
  output logic [31:0] cpu_addr,
  output logic [7:0]  cpu_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [31:0] PC32 = 32'(PIXEL_COUNT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        cpu_wr_q, cpu_wr_d;
  logic [31:0] cpu_addr_q, cpu_addr_d;
  logic [7:0]  cpu_data_q, cpu_data_d;
  logic        addr_err_q, addr_err_d;
  logic        grant0, grant1;
  logic [31:0] sel_addr;
  logic [7:0]  sel_data;

`ifdef FB_ARB_CLEAR_EN
  localparam logic [18:0] LAST_ADDR = 19'(PIXEL_COUNT - 1);
  logic [18:0] cnt_q, cnt_d;
  logic        clear_done_q, clear_done_d;
`else
  logic        unused_clear_start;
  assign unused_clear_start = clear_start;
`endif

  // Round-robin tie-break: last_grant_q==1 means requester 1 won last, so 0 wins a tie
  always_comb begin
    grant0   = req0_valid & (~req1_valid | last_grant_q);
    grant1   = req1_valid & (~req0_valid | ~last_grant_q);
    sel_addr = grant0 ? req0_addr : req1_addr;
    sel_data = grant0 ? req0_data : req1_data;
  end

  // Next-state, readies and registered-output next values
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cpu_wr_d     = 1'b0;
    cpu_addr_d   = cpu_addr_q;
    cpu_data_d   = cpu_data_q;
    addr_err_d   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
`ifdef FB_ARB_CLEAR_EN
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
`endif
    case (state_q)
      ARB: begin
        if (!reset) begin
`ifdef FB_ARB_CLEAR_EN
          if (clear_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end else
`endif
          begin
            req0_ready = grant0;
            req1_ready = grant1;
            if (grant0 | grant1) begin
              last_grant_d = grant1;
              // Out-of-range writes are consumed but only flagged, never issued
              if (sel_addr < PC32) begin
                cpu_wr_d   = 1'b1;
                cpu_addr_d = sel_addr;
                cpu_data_d = sel_data;
              end else begin
                addr_err_d = 1'b1;
              end
            end
          end
        end
      end
      CLEAR: begin
`ifdef FB_ARB_CLEAR_EN
        cpu_wr_d   = 1'b1;
        cpu_addr_d = {13'b0, cnt_q};
        cpu_data_d = CLEAR_COLOR;
        // Leaving here makes the last write and clear_done land in the same cycle
        if (cnt_q == LAST_ADDR) begin
          state_d      = ARB;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 19'd1;
        end
`else
        state_d = ARB;
`endif
      end
      default: state_d = ARB;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      cpu_wr_q     <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_data_q   <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cpu_wr_q     <= cpu_wr_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_data_q   <= cpu_data_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef FB_ARB_CLEAR_EN
  // Clear address counter and completion pulse
  always_ff @(posedge pclk) begin
    if (reset) begin
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;
`else
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  assign cpu_wr   = cpu_wr_q;
  assign cpu_addr = cpu_addr_q;
  assign cpu_data = cpu_data_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: the stimulus pushes expected writes,
// and a negedge monitor pops and compares them.
module tb_fb_write_arbiter;
`ifdef FB_ARB_CLEAR_EN
  localparam int PC = 2000;
`else
  localparam int PC = 307200;
`endif
  localparam logic [7:0] CC = 8'h5A;

  logic        pclk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_addr, req1_addr, cpu_addr;
  logic [7:0]  req0_data, req1_data, cpu_data;
  logic        clear_start, clear_busy, clear_done, addr_err, cpu_wr;

  fb_write_arbiter #(.PIXEL_COUNT(PC), .CLEAR_COLOR(CC)) dut (
    .pclk(pclk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .addr_err(addr_err), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wq[$];
  int  n_cmp = 0, n_bad = 0, err_exp = 0, done_exp = 0, done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    if (a < PC) begin
      w.a = a; w.d = d;
      wq.push_back(w);
    end else begin
      err_exp++;
    end
  endtask

  task automatic drive(input logic v0, input logic [31:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [31:0] a1, input logic [7:0] d1,
                       input logic cs);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    clear_start = cs;
  endtask

  // One cycle: drive at edge+1, check readies, queue expected writes, advance to next edge+1
  task automatic cyc(input logic v0, input logic [31:0] a0, input logic [7:0] d0,
                     input logic v1, input logic [31:0] a1, input logic [7:0] d1,
                     input logic cs, input logic er0, input logic er1);
    drive(v0, a0, d0, v1, a1, d1, cs);
    #1;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, er0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, er1});
    if (er0) push(a0, d0);
    if (er1) push(a1, d1);
    @(posedge pclk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cpu_wr", {31'b0, cpu_wr}, 32'd0);
    chk("rst_cpu_addr", cpu_addr, 32'd0);
    chk("rst_cpu_data", {24'b0, cpu_data}, 32'd0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
    chk("rst_clear_busy", {31'b0, clear_busy}, 32'd0);
    chk("rst_clear_done", {31'b0, clear_done}, 32'd0);
  endtask

  task automatic do_reset();
    drive(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0, 1'b0);
    reset = 1'b1;
    @(posedge pclk); #1;
    reset = 1'b0;
  endtask

`ifdef FB_ARB_CLEAR_EN
  task automatic run_clear(input int abort_at);
    logic aborted;
    aborted = 1'b0;
    cyc(1'b1, 32'd5, 8'hAA, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < PC; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk("rst_mid_ready0", {31'b0, req0_ready}, 32'd0);
        @(posedge pclk); #1;
        reset = 1'b0;
        drive(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0, 1'b0);
        chk_reset_vals();
        aborted = 1'b1;
        break;
      end
      drive(1'b1, 32'd5, 8'hAA, 1'b0, 32'd0, 8'd0, (k == 5));
      #1;
      chk("clr_ready0", {31'b0, req0_ready}, 32'd0);
      chk("clr_busy", {31'b0, clear_busy}, 32'd1);
      push(32'(k), CC);
      @(posedge pclk); #1;
    end
    if (!aborted) begin
      drive(1'b1, 32'd5, 8'hAA, 1'b0, 32'd0, 8'd0, 1'b0);
      #1;
      chk("clr_done_pulse", {31'b0, clear_done}, 32'd1);
      chk("clr_busy_end", {31'b0, clear_busy}, 32'd0);
      chk("clr_resume_ready0", {31'b0, req0_ready}, 32'd1);
      push(32'd5, 8'hAA);
      done_exp++;
      @(posedge pclk); #1;
      idle();
      chk("clr_done_once", {31'b0, clear_done}, 32'd0);
    end
  endtask
`endif

  // Monitor: every presented write must match the oldest expected one
  always @(negedge pclk) begin
    wr_t w;
    if (cpu_wr === 1'b1) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        w = wq.pop_front();
        chk("wr_addr", cpu_addr, w.a);
        chk("wr_data", {24'b0, cpu_data}, {24'b0, w.d});
      end
    end
    if (addr_err === 1'b1) begin
      chk("err_expected", 32'(err_exp > 0), 32'd1);
      if (err_exp > 0) err_exp--;
    end
    if (clear_done === 1'b1) done_seen++;
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 32'd1, 8'd1, 1'b1, 32'd2, 8'd2, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'b0, req1_ready}, 32'd0);
    chk_reset_vals();
    reset = 1'b0;
    drive(1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 8'd0, 1'b0);

    // Single requester, latency 1, then hold
    cyc(1'b1, 32'd100, 8'hFF, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("lat1_wr", {31'b0, cpu_wr}, 32'd1);
    idle();
    chk("idle_wr", {31'b0, cpu_wr}, 32'd0);
    chk("hold_addr", cpu_addr, 32'd100);
    chk("hold_data", {24'b0, cpu_data}, 32'hFF);

    // Round robin from reset: grants 0,1,0,1 with no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(10 + i), 8'(8'h10 + i), 1'b1, 32'(20 + i), 8'(8'h20 + i), 1'b0,
          (i % 2 == 0), (i % 2 == 1));
      chk("rr_wr", {31'b0, cpu_wr}, 32'd1);
    end
    idle();

    // Out-of-range on req1 (last grant stays 1 afterwards)
    cyc(1'b0, 32'd0, 8'd0, 1'b1, 32'(PC), 8'h33, 1'b0, 1'b0, 1'b1);
    chk("oor_no_wr", {31'b0, cpu_wr}, 32'd0);
    chk("oor_err", {31'b0, addr_err}, 32'd1);
    idle();
    chk("oor_err_once", {31'b0, addr_err}, 32'd0);
    idle();
    cyc(1'b1, 32'd7, 8'h77, 1'b1, 32'd8, 8'h88, 1'b0, 1'b1, 1'b0);
    // Last in-range address, req0 wins alone, then tie goes to req1
    cyc(1'b1, 32'(PC - 1), 8'h44, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    idle();
    cyc(1'b1, 32'd1, 8'h01, 1'b1, 32'd2, 8'h02, 1'b0, 1'b0, 1'b1);

`ifdef FB_ARB_CLEAR_EN
    idle();
    run_clear(-1);
    run_clear(1000);
    run_clear(-1);
`else
    // clear_start has no effect without the sequencer
    cyc(1'b0, 32'd0, 8'd0, 1'b1, 32'd50, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("noclr_busy", {31'b0, clear_busy}, 32'd0);
    idle();
    chk("noclr_busy2", {31'b0, clear_busy}, 32'd0);
`endif

    repeat (3) idle();
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("err_drained", 32'(err_exp), 32'd0);
    chk("done_count", 32'(done_seen), 32'(done_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
